// File: rtl/uart_pkg.sv
// Shared UART types and widths, common to the receiver and the board transmitter.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_BIT_TMR_W = 24;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle for uart_rx; the master side drives the line and baud divisor.
interface uart_rx_if;

   // DATA_VALID and FRAME_ERROR are single-cycle strobes with no back-pressure:
   // the consumer must take DATA in the cycle DATA_VALID is high.
   logic [uart_pkg::UART_BIT_TMR_W-1:0] BIT_TMR_MAX;
   logic                                UART_RX;
   logic [uart_pkg::UART_DATA_BITS-1:0] DATA;
   logic                                DATA_VALID;
   logic                                FRAME_ERROR;
   logic                                BUSY;
   uart_pkg::uart_rx_state_t            dbg_state;

   modport master (
      output BIT_TMR_MAX, UART_RX,
      input  DATA, DATA_VALID, FRAME_ERROR, BUSY, dbg_state
   );

   modport slave (
      input  BIT_TMR_MAX, UART_RX,
      output DATA, DATA_VALID, FRAME_ERROR, BUSY, dbg_state
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw RX pin, plus an optional 2-of-3 majority
// filter on the synchronised line when UART_RX_MAJORITY_EN is defined.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_s,
   output logic bit_smp_src
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = rx_i;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign rx_s = s2_q;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] tracks rx_s, [1] and [2] are rx_s one and two cycles earlier.
   logic [2:0] hist_q, hist_d;

   always_comb begin
      hist_d = {hist_q[1:0], s1_q};
   end

   always_ff @(posedge clk) begin
      if (rst) hist_q <= 3'b111;
      else     hist_q <= hist_d;
   end

   assign bit_smp_src = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                        (hist_q[1] & hist_q[2]);
`else
   assign bit_smp_src = s2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start detect, mid-bit sampling, byte strobe and framing error.
// UART_RX_MAJORITY_EN selects majority-filtered bit samples (see uart_rx_sync).
module uart_rx
   import uart_pkg::*;
(
   input  logic     CLK,
   input  logic     RESET,
   uart_rx_if.slave rx
);

   logic rx_s;
   logic bit_smp;

   uart_rx_sync u_sync (
      .clk         (CLK),
      .rst         (RESET),
      .rx_i        (rx.UART_RX),
      .rx_s        (rx_s),
      .bit_smp_src (bit_smp)
   );

   uart_rx_state_t                state_q, state_d;
   logic [UART_BIT_TMR_W-1:0]     tmr_q, tmr_d;
   logic [UART_BIT_TMR_W-1:0]     tmr_max_q, tmr_max_d;
   logic [UART_BIT_TMR_W-1:0]     half;
   logic [3:0]                    bits_q, bits_d;
   logic [UART_DATA_BITS-1:0]     shift_q, shift_d;
   logic [UART_DATA_BITS-1:0]     data_q, data_d;
   logic                          dv_q, dv_d;
   logic                          fe_q, fe_d;
   logic                          busy_q, busy_d;

   assign half = tmr_max_q >> 1;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      tmr_max_d = tmr_max_q;
      bits_d    = bits_q;
      shift_d   = shift_q;
      data_d    = data_q;
      dv_d      = 1'b0;
      fe_d      = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (!rx_s) begin
               tmr_max_d = rx.BIT_TMR_MAX;
               state_d   = START;
            end
         end
         START: begin
            if (tmr_q == half) begin
               tmr_d = '0;
               if (bit_smp) begin
                  state_d = IDLE;
               end else begin
                  bits_d  = 4'(UART_DATA_BITS);
                  state_d = DATA;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         DATA: begin
            if (tmr_q == tmr_max_q) begin
               shift_d = {bit_smp, shift_q[UART_DATA_BITS-1:1]};
               bits_d  = bits_q - 1'b1;
               tmr_d   = '0;
               if (bits_q == 4'd1) state_d = STOP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         STOP: begin
            if (tmr_q == tmr_max_q) begin
               tmr_d = '0;
               if (bit_smp) begin
                  data_d  = shift_q;
                  dv_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         BREAK: begin
            // Hold off re-arming until the line is released after a break.
            tmr_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            tmr_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         tmr_q     <= '0;
         tmr_max_q <= '0;
         bits_q    <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         tmr_max_q <= tmr_max_d;
         bits_q    <= bits_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
         busy_q    <= busy_d;
      end
   end

   assign rx.DATA        = data_q;
   assign rx.DATA_VALID  = dv_q;
   assign rx.FRAME_ERROR = fe_q;
   assign rx.BUSY        = busy_q;
   assign rx.dbg_state   = state_q;

endmodule
